// File: rtl/control_sequencer_if.sv
// Bus between the multicycle control sequencer and its fetch port, datapath select lines
// and data-memory handshake. The sequencer takes the master side.
interface control_sequencer_if #(
    parameter int N  = 8,
    parameter int PW = 8,
    parameter int IW = N + 8
);
    logic [PW-1:0] InstrAddr;
    logic          InstrReq;
    logic          InstrValid;
    logic [IW-1:0] InstrData;
    logic [1:0]    RDst3;
    logic [1:0]    RSrc1;
    logic [N-1:0]  Src2;
    logic [1:0]    ALUOp;
    logic          ALUSrc2;
    logic          ALUorM;
    logic          WE;
    logic          RegWrite;
    logic          MemReq;
    logic          MemReady;
    logic          Halted;

    modport master (
        output InstrAddr, InstrReq,
        input  InstrValid, InstrData,
        output RDst3, RSrc1, Src2,
        output ALUOp, ALUSrc2, ALUorM, WE, RegWrite, MemReq,
        input  MemReady,
        output Halted
    );

    modport slave (
        input  InstrAddr, InstrReq,
        output InstrValid, InstrData,
        input  RDst3, RSrc1, Src2,
        input  ALUOp, ALUSrc2, ALUorM, WE, RegWrite, MemReq,
        output MemReady,
        input  Halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with Moore-decoded control lines.
// Define CONTROL_SEQUENCER_PERF_EN to add saturating CycleCnt/InstrCnt performance counters.
module control_sequencer #(
    parameter int N  = 8,
    parameter int PW = 8,
    parameter int IW = N + 8
) (
    input  logic clk,
    input  logic rst,
    control_sequencer_if.master bus
`ifdef CONTROL_SEQUENCER_PERF_EN
    ,
    output logic [15:0] CycleCnt,
    output logic [15:0] InstrCnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;

    state_e        state, state_nxt;
    logic [PW-1:0] pc, pc_nxt;
    logic [IW-1:0] ir, ir_nxt;

    logic [3:0] opcode;
    logic       is_alu, is_ld, is_st, is_imm;

    logic       instr_req;
    logic [1:0] alu_op;
    logic       alu_src2;
    logic       alu_or_m;
    logic       we;
    logic       reg_write;
    logic       mem_req;
    logic       halted;

    assign opcode = ir[IW-1:IW-4];
    assign is_alu = (opcode[3:2] == 2'b00);
    assign is_ld  = (opcode == OP_LD);
    assign is_st  = (opcode == OP_ST);
    assign is_imm = (opcode == OP_ADDI) || is_ld || is_st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            // NOTE: state flops use <= so every register updates from the same pre-edge values.
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        instr_req = 1'b0;
        alu_op    = ALU_ADD;
        alu_src2  = 1'b0;
        alu_or_m  = 1'b0;
        we        = 1'b0;
        reg_write = 1'b0;
        mem_req   = 1'b0;
        halted    = 1'b0;

        case (state)
            S_FETCH: begin
                instr_req = 1'b1;
                if (bus.InstrValid) begin
                    ir_nxt    = bus.InstrData;
                    pc_nxt    = pc + PW'(1);
                    state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_JMP: begin
                        pc_nxt    = ir[PW-1:0];
                        state_nxt = S_FETCH;
                    end
                    OP_HALT: state_nxt = S_HALT;
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_ADDI, OP_LD, OP_ST: state_nxt = S_EXEC;
                    default: state_nxt = S_FETCH;
                endcase
            end

            S_EXEC: begin
                alu_src2  = is_imm;
                alu_op    = is_alu ? opcode[1:0] : ALU_ADD;
                state_nxt = (is_ld || is_st) ? S_MEM : S_WB;
            end

            // Address operands stay selected so the ALU keeps presenting the effective address.
            S_MEM: begin
                alu_src2 = 1'b1;
                alu_op   = ALU_ADD;
                mem_req  = 1'b1;
                we       = is_st;
                if (bus.MemReady) begin
                    state_nxt = is_ld ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                alu_or_m  = is_ld;
                state_nxt = S_FETCH;
            end

            S_HALT: begin
                halted    = 1'b1;
                state_nxt = S_HALT;
            end

            default: state_nxt = S_FETCH;
        endcase
    end

    assign bus.InstrAddr = pc;
    assign bus.InstrReq  = instr_req;
    assign bus.RDst3     = ir[IW-5:IW-6];
    assign bus.RSrc1     = ir[IW-7:IW-8];
    assign bus.Src2      = ir[N-1:0];
    assign bus.ALUOp     = alu_op;
    assign bus.ALUSrc2   = alu_src2;
    assign bus.ALUorM    = alu_or_m;
    assign bus.WE        = we;
    assign bus.RegWrite  = reg_write;
    assign bus.MemReq    = mem_req;
    assign bus.Halted    = halted;

`ifdef CONTROL_SEQUENCER_PERF_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic enter_fetch;

    assign enter_fetch = (state_nxt == S_FETCH) &&
                         ((state == S_DECODE) || (state == S_MEM) || (state == S_WB));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CycleCnt <= '0;
            InstrCnt <= '0;
        end else begin
            if ((state != S_HALT) && (CycleCnt != CNT_MAX)) begin
                CycleCnt <= CycleCnt + 16'd1;
            end
            if (enter_fetch && (InstrCnt != CNT_MAX)) begin
                InstrCnt <= InstrCnt + 16'd1;
            end
        end
    end
`endif

    we_regwrite_exclusive: assert property (@(posedge clk) disable iff (rst) !(we && reg_write));
    regwrite_single_cycle: assert property (@(posedge clk) disable iff (rst) reg_write |=> !reg_write);
    halted_no_fetch:       assert property (@(posedge clk) disable iff (rst) halted |-> !instr_req);

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multicycle control unit for the 8-bit datapath.
- Fetches 16-bit instructions and decodes them into register and immediate fields (RDst3, RSrc1, Src2).
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives the datapath select lines WE, ALUSrc2 and ALUorM that feed the operand/result multiplexers, plus register-file write and data-memory handshake.

Parameters:
- N, 8, datapath width; the Src2 field width.
- PW, 8, program counter width.
- IW, N+8, instruction width. Layout: [IW-1:IW-4] opcode, [IW-5:IW-6] RDst3, [IW-7:IW-8] RSrc1, [N-1:0] Src2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- InstrAddr  out  PW  fetch address; equals PC.
- InstrReq  out  1  fetch request.
- InstrValid  in  1  InstrData valid this cycle.
- InstrData  in  IW  instruction word.
- RDst3  out  2  destination/store-source register field, from IR.
- RSrc1  out  2  first source register field, from IR.
- Src2  out  N  immediate / second operand field; Src2[N-1:N-2] is the second register address.
- ALUOp  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- ALUSrc2  out  1  0 = register operand RD2, 1 = immediate Src2.
- ALUorM  out  1  0 = ALU result, 1 = ReadData to writeback.
- WE  out  1  data-memory write enable; also selects RDst3 as read address 2.
- RegWrite  out  1  register-file write strobe.
- MemReq  out  1  data-memory access request.
- MemReady  in  1  data-memory access complete.
- Halted  out  1  sequencer stopped.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: register operands.
  - 4 ADDI: immediate.
  - 5 LD: address = R[RSrc1]+Src2; RDst3 <= mem.
  - 6 ST: mem[R[RSrc1]+Src2] <= R[RDst3].
  - 7 JMP: PC <= Src2[PW-1:0].
  - F HALT.
  - 8-E: NOP.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. State, PC and IR are flops cleared asynchronously by rst.
- Reset: state FETCH, PC=0, IR=0, Halted=0. All control outputs 0 except InstrReq, which is 1 (decoded from FETCH). Deassertion takes effect on the next clk edge.
- Outputs are Moore, decoded from state and IR; no glitch-sensitive paths.
- FETCH: InstrReq=1. Waits indefinitely for InstrValid. On InstrValid: IR <= InstrData, PC <= PC+1 (modulo 2^PW, 2^PW-1 wraps to 0), go to DECODE.
- DECODE:
  - JMP: PC <= Src2[PW-1:0], go to FETCH.
  - HALT: go to HALT.
  - NOP: go to FETCH.
  - Otherwise: go to EXEC.
- EXEC: ALUOp valid. ALUSrc2=1 for ADDI/LD/ST, else 0; ALUOp=ADD for ADDI/LD/ST. ALU ops go to WB; LD/ST go to MEM.
- MEM:
  - MemReq=1 for the whole state; ALUSrc2 and ALUOp held from EXEC.
  - WE=1 for the whole state for ST, 0 for LD.
  - Stays in MEM until MemReady. LD then goes to WB; ST goes to FETCH.
  - MemReady outside MEM is ignored.
- WB: RegWrite=1 for exactly one cycle; ALUorM=1 for LD, else 0; go to FETCH.
- HALT: Halted=1, InstrReq=0, all strobes 0. Leaves only on rst.
- RDst3, RSrc1 and Src2 are driven from IR continuously; they are stable from DECODE through WB.
- Latency with zero-wait memory:
  - ALU op / ADDI: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - JMP / NOP: 2 cycles.
  - Each wait cycle adds 1.
- rst mid-instruction:
  - Aborts immediately; all outputs take reset values asynchronously.
  - A pending MemReq/WE drops within the same cycle; no partial RegWrite.
- WE and RegWrite are never asserted in the same cycle.

Optional Feature:
- Macro: CONTROL_SEQUENCER_PERF_EN.
- Defined:
  - Adds outputs CycleCnt[15:0] and InstrCnt[15:0], both reset to 0.
  - CycleCnt increments every cycle not in HALT.
  - InstrCnt increments on every transition into FETCH from DECODE, MEM or WB.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then IR=16'h4_1_0_05 (ADDI R1, R0, 5), InstrValid on cycle 1 -> EXEC has ALUSrc2=1, ALUOp=00. WB has RegWrite=1, ALUorM=0, RDst3=1. Next FETCH InstrAddr=1.
- LD with MemReady held low 3 cycles -> MemReq=1 and WE=0 for 4 cycles; then WB with ALUorM=1, RegWrite=1; total 8 cycles.
- ST 16'h6_2_1_00 -> MEM has WE=1, MemReq=1, RDst3=2; RegWrite never asserted; returns to FETCH.
- JMP Src2=8'hFE at PC=3 -> InstrAddr=8'hFE next FETCH. Then NOPs at FE, FF -> InstrAddr wraps to 00.
- rst asserted mid-MEM of ST -> WE and MemReq drop in the same cycle; PC=0; state FETCH.
- HALT 16'hF000 -> Halted=1, InstrReq=0 indefinitely with InstrValid toggling. With CONTROL_SEQUENCER_PERF_EN, CycleCnt freezes.
